// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory requests for loads/stores, stalls the
// pipeline while a request is outstanding, formats load data and flags faults.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        exe_valid,
    input  logic [3:0]  exe_memop,
    input  logic [4:0]  exe_wa,
    input  logic        exe_wreg,
    input  logic [31:0] exe_wd,
    input  logic [31:0] exe_din,
    input  logic        exe_whilo,
    input  logic [63:0] exe_hilo,
    input  logic        flush,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  mem_wa,
    output logic        mem_wreg,
    output logic [31:0] mem_dreg,
    output logic        mem_mreg,
    output logic [3:0]  mem_dre,
    output logic        mem_whilo,
    output logic [63:0] mem_hilo,
    output logic        stall_req,
    output logic        mem_err
);

    // state | meaning
    // IDLE  | no request outstanding; non-memory ops pass straight through
    // BUSY  | request outstanding, pipeline stalled, bubble into MEM/WB
    // DONE  | one-cycle write-back of the completed load/store
    // DRAIN | flushed while outstanding; wait out the ack, no write-back
    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic half, word;
        half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word = (op == OP_LW) || (op == OP_SW);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

    function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] lo);
        logic [3:0] be;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << lo;
            OP_LH, OP_LHU, OP_SH: be = lo[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] din);
        logic [31:0] wd;
        case (op)
            OP_SB:   wd = {4{din[7:0]}};
            OP_SH:   wd = {2{din[15:0]}};
            OP_SW:   wd = din;
            default: wd = 32'h0;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] lo,
                                              input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ld;
        b = 8'(rd >> {lo, 3'b000});
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   ld = {{24{b[7]}}, b};
            OP_LBU:  ld = {24'h0, b};
            OP_LH:   ld = {{16{h[15]}}, h};
            OP_LHU:  ld = {16'h0, h};
            OP_LW:   ld = rd;
            default: ld = 32'h0;
        endcase
        return ld;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ldata_q, ldata_d;
    logic        timeout_q, timeout_d;
    logic        start;
    logic        is_mem;

    // Request attributes captured at issue so the bus stays stable even if
    // EX/MEM changes underneath a flushed (draining) request.
    logic [3:0]  op_q;
    logic [1:0]  lo2_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;

    assign is_mem = exe_valid && (exe_memop >= OP_LB) && (exe_memop <= OP_SW) && !flush;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ldata_q   <= '0;
            timeout_q <= 1'b0;
            op_q      <= '0;
            lo2_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ldata_q   <= ldata_d;
            timeout_q <= timeout_d;
            if (start) begin
                op_q    <= exe_memop;
                lo2_q   <= exe_wd[1:0];
                addr_q  <= exe_wd[31:2];
                be_q    <= byte_en(exe_memop, exe_wd[1:0]);
                wdata_q <= store_data(exe_memop, exe_din);
                we_q    <= is_store(exe_memop);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ldata_d   = ldata_q;
        timeout_d = timeout_q;
        start     = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_be     = '0;
        dm_wdata  = '0;
        mem_wa    = '0;
        mem_wreg  = 1'b0;
        mem_dreg  = '0;
        mem_mreg  = 1'b0;
        mem_dre   = '0;
        mem_whilo = 1'b0;
        mem_hilo  = '0;
        stall_req = 1'b0;
        mem_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    if (misaligned(exe_memop, exe_wd[1:0])) begin
                        mem_err = 1'b1;
                    end else begin
                        start     = 1'b1;
                        dm_req    = 1'b1;
                        dm_we     = is_store(exe_memop);
                        dm_addr   = {exe_wd[31:2], 2'b00};
                        dm_be     = byte_en(exe_memop, exe_wd[1:0]);
                        dm_wdata  = store_data(exe_memop, exe_din);
                        stall_req = 1'b1;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        state_d   = BUSY;
                    end
                end else if (!flush) begin
                    mem_wa    = exe_wa;
                    mem_wreg  = exe_wreg;
                    mem_dreg  = exe_wd;
                    mem_whilo = exe_whilo;
                    mem_hilo  = exe_hilo;
                end
            end
            BUSY, DRAIN: begin
                stall_req = (state_q == BUSY);
                if (cnt_q == TO_CNT) begin
                    // Timeout: request already dropped, so a late ack is not ours.
                    mem_err   = 1'b1;
                    timeout_d = 1'b1;
                    ldata_d   = '0;
                    state_d   = (state_q == BUSY) ? DONE : IDLE;
                end else begin
                    dm_req   = 1'b1;
                    dm_we    = we_q;
                    dm_addr  = {addr_q, 2'b00};
                    dm_be    = be_q;
                    dm_wdata = wdata_q;
                    if (dm_ack) begin
                        ldata_d = load_data(op_q, lo2_q, dm_rdata);
                        state_d = (state_q == BUSY && !flush) ? DONE : IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (state_q == BUSY && flush) state_d = DRAIN;
                    end
                end
            end
            DONE: begin
                mem_wa    = exe_wa;
                mem_wreg  = exe_wreg && !timeout_q && !flush;
                mem_dreg  = is_load(op_q) ? ldata_q : exe_wd;
                mem_mreg  = is_load(op_q);
                mem_dre   = be_q;
                mem_whilo = exe_whilo && !timeout_q && !flush;
                mem_hilo  = exe_hilo;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cpu_rst) begin
            dm_req    = 1'b0;
            dm_we     = 1'b0;
            dm_addr   = '0;
            dm_be     = '0;
            dm_wdata  = '0;
            mem_wa    = '0;
            mem_wreg  = 1'b0;
            mem_dreg  = '0;
            mem_mreg  = 1'b0;
            mem_dre   = '0;
            mem_whilo = 1'b0;
            mem_hilo  = '0;
            stall_req = 1'b0;
            mem_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a transaction-level model predicts every
// output each cycle; literal checks pin the model on the headline scenarios.
module tb_mem_stage_ctrl;

    localparam int TO = 4;
    localparam logic [63:0] HILO = 64'h0123_4567_89AB_CDEF;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic        exe_valid;
    logic [3:0]  exe_memop;
    logic [4:0]  exe_wa;
    logic        exe_wreg;
    logic [31:0] exe_wd;
    logic [31:0] exe_din;
    logic        exe_whilo;
    logic [63:0] exe_hilo;
    logic        flush;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [4:0]  mem_wa;
    logic        mem_wreg, mem_mreg, mem_whilo, stall_req, mem_err;
    logic [31:0] mem_dreg;
    logic [3:0]  mem_dre;
    logic [63:0] mem_hilo;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
        .exe_valid(exe_valid), .exe_memop(exe_memop), .exe_wa(exe_wa),
        .exe_wreg(exe_wreg), .exe_wd(exe_wd), .exe_din(exe_din),
        .exe_whilo(exe_whilo), .exe_hilo(exe_hilo), .flush(flush),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_wa(mem_wa), .mem_wreg(mem_wreg), .mem_dreg(mem_dreg),
        .mem_mreg(mem_mreg), .mem_dre(mem_dre), .mem_whilo(mem_whilo),
        .mem_hilo(mem_hilo), .stall_req(stall_req), .mem_err(mem_err)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 0;

    logic        e_req, e_we, e_wreg, e_mreg, e_whilo, e_stall, e_err;
    logic [31:0] e_addr, e_wdata, e_dreg;
    logic [3:0]  e_be, e_dre;
    logic [4:0]  e_wa;
    logic [63:0] e_hilo;

    int n_stall, n_err, n_req, n_wb;
    logic [3:0]  cap_be, cap_dre;
    logic [31:0] cap_wdata, cap_dreg;
    logic        cap_we, cap_wreg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge cpu_clk_50M) begin
        if (chk_on) begin
            chk("dm_req", dm_req, e_req);
            chk("dm_we", dm_we, e_we);
            chk("dm_addr", dm_addr, e_addr);
            chk("dm_be", dm_be, e_be);
            chk("dm_wdata", dm_wdata, e_wdata);
            chk("mem_wa", mem_wa, e_wa);
            chk("mem_wreg", mem_wreg, e_wreg);
            chk("mem_dreg", mem_dreg, e_dreg);
            chk("mem_mreg", mem_mreg, e_mreg);
            chk("mem_dre", mem_dre, e_dre);
            chk("mem_whilo", mem_whilo, e_whilo);
            chk("mem_hilo", mem_hilo, e_hilo);
            chk("stall_req", stall_req, e_stall);
            chk("mem_err", mem_err, e_err);
        end
    end

    // Reference formatting rules, expressed arithmetically.
    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        case (op)
            1, 2, 6: return 4'(1 << lo);
            3, 4, 7: return (lo >= 2) ? 4'hC : 4'h3;
            5, 8:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            6:       return {24'h0, d[7:0]} * 32'h0101_0101;
            7:       return {16'h0, d[15:0]} * 32'h0001_0001;
            8:       return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        int lo = int'(a % 4);
        logic [31:0] b, h;
        b = (rd >> (8 * lo)) & 32'hFF;
        h = (rd >> (8 * (lo & 2))) & 32'hFFFF;
        case (op)
            1:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            2:       return b;
            3:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4:       return h;
            5:       return rd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
        return ((op == 3 || op == 4 || op == 7) && (a % 2 != 0)) ||
               ((op == 5 || op == 8) && (a % 4 != 0));
    endfunction

    task automatic exp_zero();
        e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
        e_wa = 0; e_wreg = 0; e_dreg = 0; e_mreg = 0; e_dre = 0;
        e_whilo = 0; e_hilo = 0; e_stall = 0; e_err = 0;
    endtask

    task automatic exp_pass();
        exp_zero();
        e_wa = exe_wa; e_wreg = exe_wreg; e_dreg = exe_wd;
        e_whilo = exe_whilo; e_hilo = exe_hilo;
    endtask

    task automatic exp_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        e_req = 1; e_we = (op >= 6); e_addr = a & 32'hFFFF_FFFC;
        e_be = m_be(op, a); e_wdata = m_wdata(op, d);
    endtask

    // ph: 1 = capture request-cycle bus, 2 = capture write-back cycle
    task automatic tick(input int ph);
        @(negedge cpu_clk_50M);
        if (stall_req) n_stall++;
        if (mem_err)   n_err++;
        if (dm_req)    n_req++;
        if (mem_wreg)  n_wb++;
        if (ph == 1) begin cap_be = dm_be; cap_wdata = dm_wdata; cap_we = dm_we; end
        if (ph == 2) begin cap_dreg = mem_dreg; cap_wreg = mem_wreg; cap_dre = mem_dre; end
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic run_alu(input logic valid, input logic [3:0] op, input logic [4:0] wa,
                           input logic wreg, input logic [31:0] wd, input logic whilo,
                           input logic ack);
        exe_valid = valid; exe_memop = op; exe_wa = wa; exe_wreg = wreg; exe_wd = wd;
        exe_din = 32'h5555_AAAA; exe_whilo = whilo; exe_hilo = ~HILO;
        flush = 0; dm_ack = ack; dm_rdata = 32'hFFFF_FFFF;
        exp_pass();
        tick(0);
        dm_ack = 0;
    endtask

    // ack_at / flush_at: index of the waiting cycle (1 = first after issue), 0 = never
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] din,
                           input logic [4:0] wa, input logic wreg, input int ack_at,
                           input logic [31:0] rdata, input int flush_at, input bit flush_done);
        bit ld, flushed, timed_out;
        ld = (op >= 1 && op <= 5);
        flushed = 0; timed_out = 0;
        n_stall = 0; n_err = 0; n_req = 0; n_wb = 0;
        cap_be = 0; cap_wdata = 0; cap_we = 0; cap_dreg = 0; cap_wreg = 0; cap_dre = 0;
        exe_valid = 1; exe_memop = op; exe_wa = wa; exe_wreg = wreg; exe_wd = addr;
        exe_din = din; exe_whilo = 0; exe_hilo = HILO; flush = 0; dm_ack = 0; dm_rdata = 0;
        exp_zero();
        if (m_mis(op, addr)) begin
            e_err = 1;
            tick(0);
            return;
        end
        exp_req(op, addr, din);
        e_stall = 1;
        tick(1);
        for (int k = 1; k <= TO + 1; k++) begin
            exp_zero();
            if (k - 1 == TO) begin
                flush = 0; dm_ack = 0;
                e_err = 1; e_stall = !flushed;
                timed_out = 1;
                tick(0);
                break;
            end
            flush = (k == flush_at);
            dm_ack = (k == ack_at);
            dm_rdata = rdata;
            exp_req(op, addr, din);
            e_stall = !flushed;
            tick(0);
            if (flush) flushed = 1;
            if (dm_ack) break;
        end
        flush = 0; dm_ack = 0;
        if (!flushed) begin
            exp_zero();
            e_wa = wa;
            e_wreg = wreg && !timed_out && !flush_done;
            e_dreg = ld ? (timed_out ? 32'h0 : m_load(op, addr, rdata)) : addr;
            e_mreg = ld;
            e_dre = m_be(op, addr);
            e_hilo = HILO;
            flush = flush_done;
            tick(2);
            flush = 0;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rst = 1;
        exe_valid = 1; exe_memop = 4'd5; exe_wa = 5'd3; exe_wreg = 1; exe_wd = 32'h100;
        exe_din = 32'h1; exe_whilo = 1; exe_hilo = HILO; flush = 0; dm_ack = 1; dm_rdata = 32'h1;
        exp_zero();
        chk_on = 1;
        @(posedge cpu_clk_50M);
        #1;
        tick(0);
        tick(0);
        cpu_rst = 0; dm_ack = 0;

        // Pass-through in IDLE, including invalid/unused op codes and a stray ack.
        run_alu(1, 4'd0, 5'd7, 1, 32'hCAFE_0001, 1, 0);
        run_alu(1, 4'd12, 5'd31, 1, 32'h0000_0103, 0, 0);
        run_alu(0, 4'd5, 5'd9, 0, 32'h0000_0200, 1, 1);

        run_mem(4'd5, 32'h100, 32'h0, 5'd4, 1, 3, 32'hDEAD_BEEF, 0, 0);
        chk("lw_stall_cycles", n_stall, 4);
        chk("lw_dreg", cap_dreg, 32'hDEAD_BEEF);
        chk("lw_wreg", cap_wreg, 1);
        chk("lw_dre", cap_dre, 4'hF);
        run_alu(1, 4'd0, 5'd1, 1, 32'h11, 0, 0);

        run_mem(4'd1, 32'h103, 32'h0, 5'd5, 1, 1, 32'h80FF_FFFF, 0, 0);
        chk("lb_sext", cap_dreg, 32'hFFFF_FF80);
        run_mem(4'd2, 32'h103, 32'h0, 5'd5, 1, 2, 32'h80FF_FFFF, 0, 0);
        chk("lbu_zext", cap_dreg, 32'h0000_0080);

        run_mem(4'd7, 32'h102, 32'h1234_ABCD, 5'd0, 0, 1, 32'h0, 0, 0);
        chk("sh_be", cap_be, 4'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", cap_we, 1);
        chk("sh_no_wb", n_wb, 0);

        run_mem(4'd6, 32'h201, 32'h0000_00A5, 5'd0, 0, 1, 32'h0, 0, 0);
        run_mem(4'd3, 32'h102, 32'h0, 5'd6, 1, 1, 32'h8001_7F00, 0, 0);
        run_mem(4'd4, 32'h100, 32'h0, 5'd6, 1, 2, 32'h1234_F00D, 0, 0);
        run_mem(4'd8, 32'h300, 32'h7654_3210, 5'd0, 0, 1, 32'h0, 0, 0);
        run_mem(4'd6, 32'h103, 32'h0000_003C, 5'd0, 0, 1, 32'h0, 0, 0);
        run_mem(4'd1, 32'h101, 32'h0, 5'd8, 1, 1, 32'h1122_3344, 0, 0);

        run_mem(4'd5, 32'h101, 32'h0, 5'd4, 1, 1, 32'h0, 0, 0);
        chk("mis_err", n_err, 1);
        chk("mis_no_req", n_req, 0);
        chk("mis_no_stall", n_stall, 0);
        chk("mis_no_wb", n_wb, 0);
        run_mem(4'd7, 32'h101, 32'h0, 5'd0, 0, 1, 32'h0, 0, 0);
        run_mem(4'd3, 32'h103, 32'h0, 5'd2, 1, 1, 32'h0, 0, 0);
        run_alu(1, 4'd0, 5'd2, 1, 32'h22, 0, 0);

        run_mem(4'd5, 32'h104, 32'h0, 5'd4, 1, 0, 32'h0, 0, 0);
        chk("to_err_pulse", n_err, 1);
        chk("to_no_wb", n_wb, 0);
        chk("to_stall_cycles", n_stall, 2 + TO);
        run_alu(1, 4'd0, 5'd3, 1, 32'h33, 0, 0);

        run_mem(4'd5, 32'h108, 32'h0, 5'd4, 1, 4, 32'h1357_9BDF, 2, 0);
        chk("flush_req_held", n_req, 5);
        chk("flush_no_wb", n_wb, 0);
        run_alu(1, 4'd0, 5'd4, 1, 32'h44, 1, 0);

        run_mem(4'd5, 32'h10C, 32'h0, 5'd4, 1, 0, 32'h0, 1, 0);
        chk("drain_to_err", n_err, 1);
        run_alu(1, 4'd0, 5'd5, 1, 32'h55, 0, 0);

        run_mem(4'd5, 32'h110, 32'h0, 5'd4, 1, 1, 32'h2468_ACE0, 0, 1);
        chk("done_flush_no_wb", n_wb, 0);
        run_alu(1, 4'd0, 5'd6, 1, 32'h66, 0, 0);

        // Flush in IDLE forces reset-value outputs even for a valid aligned op.
        exe_valid = 1; exe_memop = 4'd5; exe_wa = 5'd9; exe_wreg = 1; exe_wd = 32'h200;
        exe_whilo = 1; exe_hilo = HILO; flush = 1; dm_ack = 0;
        exp_zero();
        tick(0);
        flush = 0;

        // Reset while a request is outstanding, then a stray ack afterwards.
        exe_valid = 1; exe_memop = 4'd5; exe_wa = 5'd9; exe_wreg = 1; exe_wd = 32'h200;
        exe_din = 0; exe_whilo = 0; exe_hilo = HILO; flush = 0; dm_ack = 0;
        exp_zero(); exp_req(4'd5, 32'h200, 32'h0); e_stall = 1;
        tick(0);
        tick(0);
        cpu_rst = 1;
        exp_zero();
        tick(0);
        cpu_rst = 0;
        run_alu(1, 4'd0, 5'd10, 1, 32'h77, 1, 1);
        run_mem(4'd2, 32'h202, 32'h0, 5'd11, 1, 1, 32'h00AB_0000, 0, 0);
        chk("post_reset_lbu", cap_dreg, 32'h0000_00AB);
        run_alu(1, 4'd0, 5'd12, 0, 32'h88, 0, 0);

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 255, the maximum number of cycles spent waiting for dm_ack.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port cpu_clk_50M, in, 1: the single clock; all state updates on its rising edge.
REQ-004 Port cpu_rst, in, 1: synchronous, active-high reset.
REQ-005 Port exe_valid, in, 1: the EX/MEM register holds a live instruction.
REQ-006 Port exe_memop, in, 4: the memory operation code, encoded as follows.
- 0 = none, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU, 5 = LW, 6 = SB, 7 = SH, 8 = SW.
- Codes 9-15 are treated as none.
REQ-007 Ports exe_wa (in, 5), exe_wreg (in, 1), exe_wd (in, 32): the destination register, the write enable, and the ALU result, which is also the memory address.
REQ-008 Port exe_din, in, 32: the store data.
REQ-009 Ports exe_whilo (in, 1) and exe_hilo (in, 64): the HI/LO write enable and value, passed through.
REQ-010 Port flush, in, 1: discard the current instruction.
REQ-011 Ports to the data memory: dm_req (out, 1), dm_we (out, 1), dm_addr (out, 32), dm_be (out, 4), dm_wdata (out, 32).
REQ-012 Ports from the data memory: dm_ack (in, 1), dm_rdata (in, 32).
REQ-013 Ports mem_wa (out, 5), mem_wreg (out, 1), mem_dreg (out, 32), mem_mreg (out, 1), mem_dre (out, 4), mem_whilo (out, 1), mem_hilo (out, 64): these feed the MEM/WB register.
REQ-014 Port stall_req (out, 1): hold the IF..EX stages and EX/MEM.
REQ-015 Port mem_err (out, 1): a one-cycle misalignment or timeout flag.

Function
REQ-016 The state machine SHALL have four states: IDLE, BUSY, DONE and DRAIN.
REQ-017 A memory op SHALL mean exe_valid=1, exe_memop in 1..8, and flush=0.
REQ-018 Non-memory instruction in IDLE: all mem_* outputs SHALL equal the exe_* inputs in the same cycle, with mem_mreg=0, mem_dre=0 and stall_req=0.
REQ-019 Misalignment SHALL be defined as follows.
- LH, LHU or SH with exe_wd[0]=1.
- LW or SW with exe_wd[1:0]!=0.
REQ-020 A misaligned memory op in IDLE SHALL produce the following in the same cycle, and the state SHALL stay IDLE.
- No request is issued.
- mem_err=1, mem_wreg=0, mem_whilo=0, stall_req=0.
REQ-021 An aligned memory op in IDLE SHALL assert dm_req and stall_req combinationally, and the state SHALL move to BUSY next cycle.
REQ-022 dm_addr SHALL equal exe_wd with bits [1:0] forced to 0.
REQ-023 dm_we SHALL be 1 for SB, SH and SW.
REQ-024 Byte enables SHALL be little-endian, as follows.
- SB/LB/LBU: be = 1<<addr[1:0].
- SH/LH/LHU: be = 0011 if addr[1]=0, else 1100.
- SW/LW: be = 1111.
REQ-025 dm_wdata SHALL replicate the store data: the byte 4 times (SB), the halfword twice (SH), or the word unchanged (SW).
REQ-026 dm_req, dm_we, dm_addr, dm_be and dm_wdata SHALL remain stable from assertion until the cycle dm_ack=1 is sampled; dm_req SHALL never be withdrawn before then.
REQ-027 BUSY with dm_ack=1: the block SHALL drop dm_req next cycle, latch the formatted load data, and move to DONE.
REQ-028 Load formatting SHALL select the addressed byte or halfword from dm_rdata.
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- LW passes the word unchanged.
REQ-029 In BUSY: stall_req=1 and mem_wreg=mem_whilo=0, so that a bubble enters MEM/WB.
REQ-030 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-031 If the counter reaches TIMEOUT in BUSY, the block SHALL deassert dm_req, pulse mem_err=1 for one cycle, and enter DONE with write-back suppressed.
REQ-032 DONE SHALL last exactly one cycle, with the following outputs, then return to IDLE unconditionally.
- stall_req=0.
- mem_wa=exe_wa, mem_dreg = latched data for a load, else exe_wd.
- mem_wreg=exe_wreg, except 0 after a timeout.
- mem_mreg=1 for a load; mem_dre = the op's byte enables.
REQ-033 flush in IDLE: all outputs SHALL be forced to their reset values that cycle.
REQ-034 flush in BUSY without ack: move to DRAIN, keep dm_req high, and keep mem_wreg=0.
REQ-035 DRAIN SHALL wait for dm_ack or timeout, discard the data, and return to IDLE with no write-back and stall_req=0 throughout.
REQ-036 flush in DONE: write-back SHALL be suppressed; return to IDLE.
REQ-037 dm_ack sampled in IDLE or DONE SHALL be ignored.

Reset
REQ-038 When cpu_rst=1 at a clock edge, the state SHALL become IDLE, the counter 0, and the latched data 0.
REQ-039 While cpu_rst=1, all outputs SHALL be 0: dm_*, mem_*, stall_req and mem_err.
REQ-040 Reset during BUSY or DRAIN SHALL abandon the transaction immediately, and a later stray dm_ack SHALL be ignored.

Verification
REQ-041 LW at address 0x100, with ack on the 3rd BUSY cycle and rdata 0xDEADBEEF, SHALL produce the following.
- stall_req high for 4 cycles.
- DONE with mem_dreg=0xDEADBEEF, mem_wreg=1, mem_dre=1111.
REQ-042 LB at address 0x103 with rdata 0x80FFFFFF SHALL give mem_dreg=0xFFFFFF80; LBU at the same address SHALL give 0x00000080.
REQ-043 SH at address 0x102 with din=0x1234ABCD SHALL drive the following, with no register write in DONE.
- dm_be=1100, dm_wdata=0xABCDABCD, dm_we=1.
REQ-044 LW at address 0x101 SHALL produce mem_err=1 and mem_wreg=0 with no dm_req and no stall.
REQ-045 With TIMEOUT=4 and no ack, mem_err SHALL pulse after 4 BUSY cycles, followed by DONE with mem_wreg=0.
REQ-046 flush in the 2nd BUSY cycle, followed by ack 2 cycles later, SHALL keep dm_req held until the ack, produce no write-back, and return to IDLE the next cycle.
